id_inst_queue: RTL and testbench
================================

// Module: id_inst_queue
// PURPOSE
//  Parametrised decoupling queue between IF and the ID decode logic. It is the successor of the single
//  IF->ID register: it holds up to DEPTH fetched {PC_plus_4, inst} entries, so IF keeps fetching
//  while ID is stalled by hazards. It handles taken-branch redirect with MIPS delay-slot retention
//  and drops a fixed number of wrong-path fetches that were already in flight.
// PARAMETERS
//  DEPTH       4   entry count; power of two, 2..16
//  DATA_WD     64  entry width ({PC_plus_4[31:0], inst[31:0]})
//  DELAY_SLOT  1   1: keep the delay-slot instruction on redirect; 0: flush all
//  SKIP_INFL   0   wrong-path pushes to discard after a redirect (0..3)
// PORTS
//  clk              in   1                    clock, rising edge
//  reset            in   1                    asynchronous, active-low (0 = reset)
//  IF_to_ID_valid   in   1                    IF offers an entry
//  IF_to_ID_bus     in   DATA_WD              offered entry
//  ID_allow_in      out  1                    queue can accept (not full)
//  ST_ready         in   1                    hazard unit: head may leave (ready_go)
//  EXE_allow_in     in   1                    EXE accepts
//  ID_to_EXE_valid  out  1                    head entry valid and ready
//  head_bus         out  DATA_WD              oldest entry (0 when empty)
//  br_redirect      in   1                    head is a taken branch/jump; qualified by pop
//  occupancy        out  $clog2(DEPTH+1)      stored entry count
// BEHAVIOUR
//  - Reset (async): rd_ptr = wr_ptr = 0, occupancy = 0, skip_cnt = 0.
//    ID_allow_in = 1, ID_to_EXE_valid = 0, head_bus = 0.
//  - push = IF_to_ID_valid & ID_allow_in.
//  - pop = ID_to_EXE_valid & EXE_allow_in.
//  - ID_allow_in = (occupancy != DEPTH). It does not depend on pop, so there is no combinational
//    path from EXE_allow_in to IF.
//  - ID_to_EXE_valid = (occupancy != 0) & ST_ready. head_bus = mem[rd_ptr] combinationally: zero latency
//    from storage, one-cycle latency from push to head.
//  - Pointers wrap modulo DEPTH. Simultaneous push and pop keep occupancy unchanged. Overflow and
//    underflow are impossible by construction.
//  - br_redirect is ignored unless pop occurs in the same cycle.
//  - Redirect, DELAY_SLOT=1:
//    - If occupancy >= 2, the entry at rd_ptr+1 is kept as the new head, occupancy becomes 1,
//      and a same-cycle push is dropped.
//    - If occupancy == 1 and push, the pushed entry is kept (occupancy 1).
//    - If occupancy == 1 and no push, the queue empties and the next accepted push is the delay slot.
//      A ds_wait flag stays set until that push.
//  - Redirect, DELAY_SLOT=0: the queue empties, including a same-cycle push.
//  - skip_cnt loads SKIP_INFL once the delay slot is stored. While skip_cnt != 0, each push is
//    accepted but discarded and decrements skip_cnt.
//  - A new redirect overrides any pending ds_wait and skip_cnt state.
//  - Reset asserted mid-operation discards all entries immediately. Outputs return to reset values
//    asynchronously.
// TESTING
//  - Fill: push A,B,C,D with ST_ready=0 -> occupancy 4, ID_allow_in=0, E held off.
//    Then ST_ready=1, EXE_allow_in=1 -> A,B,C,D leave in order, one per cycle.
//  - Concurrent push/pop at occupancy 2 for 10 cycles -> occupancy stays 2, order preserved, pointers
//    wrap correctly.
//  - Redirect with occupancy 3 (branch, ds, X), DELAY_SLOT=1, plus a same-cycle push Y ->
//    next head = ds, occupancy 1, X and Y never appear.
//  - Redirect with occupancy 1 and no push, SKIP_INFL=1 -> queue empty.
//    Next push P is kept as the delay slot; the following push Q is dropped; push R becomes valid.
//  - DELAY_SLOT=0 redirect with occupancy 4 and a same-cycle push -> occupancy 0, ID_to_EXE_valid=0
//    the next cycle.
//  - reset=0 with occupancy 3 mid-stall -> occupancy 0, ID_to_EXE_valid=0, head_bus=0 without a clock
//    edge; normal operation after release.

Source files
------------

// File: rtl/id_inst_queue_if.sv
// ---------------------------------------------------------------------------
// id_inst_queue_if
// Bundles the IF-side push handshake, the ID/EXE-side pop handshake, the
// redirect strobe and the queue status so the decode queue and its
// neighbours connect through a single port.
//   IF_to_ID_valid  IF offers an entry                  (master -> slave)
//   IF_to_ID_bus    offered {PC_plus_4, inst}            (master -> slave)
//   ID_allow_in     queue can accept                     (slave -> master)
//   ST_ready        hazard unit lets the head leave      (master -> slave)
//   EXE_allow_in    EXE accepts                          (master -> slave)
//   ID_to_EXE_valid head entry valid and ready           (slave -> master)
//   head_bus        oldest entry, 0 when empty           (slave -> master)
//   br_redirect     head is a taken branch/jump          (master -> slave)
//   occupancy       stored entry count                   (slave -> master)
// ---------------------------------------------------------------------------
interface id_inst_queue_if #(
  parameter int DEPTH   = 4,
  parameter int DATA_WD = 64
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic               IF_to_ID_valid;
  logic [DATA_WD-1:0] IF_to_ID_bus;
  logic               ID_allow_in;
  logic               ST_ready;
  logic               EXE_allow_in;
  logic               ID_to_EXE_valid;
  logic [DATA_WD-1:0] head_bus;
  logic               br_redirect;
  logic [OCC_W-1:0]   occupancy;

  modport master (
    output IF_to_ID_valid, IF_to_ID_bus, ST_ready, EXE_allow_in, br_redirect,
    input  ID_allow_in, ID_to_EXE_valid, head_bus, occupancy
  );

  modport slave (
    input  IF_to_ID_valid, IF_to_ID_bus, ST_ready, EXE_allow_in, br_redirect,
    output ID_allow_in, ID_to_EXE_valid, head_bus, occupancy
  );
endinterface

// File: rtl/id_inst_queue.sv
// ---------------------------------------------------------------------------
// id_inst_queue
// Decoupling queue between instruction fetch and decode. Holds up to DEPTH
// fetched {PC_plus_4, inst} entries so fetch continues while decode stalls.
// A taken branch leaving the head (br_redirect qualified by pop) flushes the
// wrong path, optionally keeping the MIPS delay-slot instruction, and can
// discard SKIP_INFL further wrong-path fetches that were already in flight.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   q      id_inst_queue_if.slave (push/pop handshakes, head, occupancy)
// ---------------------------------------------------------------------------
module id_inst_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WD    = 64,
  parameter int DELAY_SLOT = 1,
  parameter int SKIP_INFL  = 0
) (
  input  logic           clk,
  input  logic           reset,
  id_inst_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [1:0] SKIP_INIT = 2'(SKIP_INFL);

  logic [DATA_WD-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r, wr_ptr_r;
  logic [OCC_W-1:0]   occ_r;
  logic [1:0]         skip_cnt_r;
  logic               ds_wait_r;

  logic [PTR_W-1:0]   rd_ptr_nxt_s, wr_ptr_nxt_s;
  logic [OCC_W-1:0]   occ_nxt_s;
  logic [1:0]         skip_nxt_s;
  logic               ds_wait_nxt_s;
  logic               wr_en_s;
  logic               push_s, pop_s, redirect_s, not_empty_s;

  // Handshakes: allow_in looks only at stored state, so EXE_allow_in never
  // reaches the IF side combinationally.
  assign not_empty_s       = (occ_r != {OCC_W{1'b0}});
  assign q.ID_allow_in     = (occ_r != OCC_W'(DEPTH));
  assign q.ID_to_EXE_valid = not_empty_s & q.ST_ready;
  assign q.head_bus        = not_empty_s ? mem_r[rd_ptr_r] : {DATA_WD{1'b0}};
  assign q.occupancy       = occ_r;

  assign push_s     = q.IF_to_ID_valid & q.ID_allow_in;
  assign pop_s      = q.ID_to_EXE_valid & q.EXE_allow_in;
  assign redirect_s = pop_s & q.br_redirect;

  // Next-state: redirect handling takes priority over skip/delay-slot state.
  always_comb begin
    rd_ptr_nxt_s  = rd_ptr_r;
    wr_ptr_nxt_s  = wr_ptr_r;
    occ_nxt_s     = occ_r;
    skip_nxt_s    = skip_cnt_r;
    ds_wait_nxt_s = ds_wait_r;
    wr_en_s       = 1'b0;
    if (redirect_s) begin
      ds_wait_nxt_s = 1'b0;
      skip_nxt_s    = SKIP_INIT;
      if (DELAY_SLOT != 0) begin
        if (occ_r >= OCC_W'(2)) begin
          // Delay slot already stored behind the branch: it becomes the only entry.
          rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
          wr_ptr_nxt_s = rd_ptr_r + PTR_W'(2);
          occ_nxt_s    = OCC_W'(1);
        end else if (push_s) begin
          // The delay slot arrives in the same cycle the branch leaves.
          wr_en_s      = 1'b1;
          rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
          wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
          occ_nxt_s    = OCC_W'(1);
        end else begin
          // Delay slot not fetched yet: wait for it before skipping.
          rd_ptr_nxt_s  = rd_ptr_r + PTR_W'(1);
          occ_nxt_s     = {OCC_W{1'b0}};
          ds_wait_nxt_s = 1'b1;
          skip_nxt_s    = 2'd0;
        end
      end else begin
        rd_ptr_nxt_s = wr_ptr_r;
        occ_nxt_s    = {OCC_W{1'b0}};
      end
    end else begin
      if (push_s && (skip_cnt_r != 2'd0)) begin
        // Accepted but discarded wrong-path fetch.
        skip_nxt_s = skip_cnt_r - 2'd1;
      end else if (push_s) begin
        wr_en_s      = 1'b1;
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
        if (ds_wait_r) begin
          ds_wait_nxt_s = 1'b0;
          skip_nxt_s    = SKIP_INIT;
        end else begin
          ds_wait_nxt_s = ds_wait_r;
        end
      end else begin
        wr_en_s = 1'b0;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      occ_nxt_s = occ_r + OCC_W'(wr_en_s) - OCC_W'(pop_s);
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      occ_r      <= {OCC_W{1'b0}};
      skip_cnt_r <= 2'd0;
      ds_wait_r  <= 1'b0;
    end else begin
      rd_ptr_r   <= rd_ptr_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      occ_r      <= occ_nxt_s;
      skip_cnt_r <= skip_nxt_s;
      ds_wait_r  <= ds_wait_nxt_s;
    end
  end

  // Entry storage; contents are don't-care while occupancy masks them.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= q.IF_to_ID_bus;
    end
  end
endmodule

// File: tb/tb_id_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_id_inst_queue
// Drives three queue configurations with identical stimulus:
//   0: DELAY_SLOT=1 SKIP_INFL=0   1: DELAY_SLOT=1 SKIP_INFL=1   2: DELAY_SLOT=0
// A list-based reference model predicts every output each cycle; the
// expectations go into a scoreboard queue consumed by an independent monitor.
// ---------------------------------------------------------------------------
module tb_id_inst_queue;
  logic clk;
  logic reset;

  typedef struct packed {
    logic [1:0]  k;
    logic        allow;
    logic        valid;
    logic [63:0] head;
    logic [2:0]  occ;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  logic [63:0] mq    [3][4];
  int          mcnt  [3];
  bit          mdsw  [3];
  int          mskip [3];

  id_inst_queue_if #(.DEPTH(4), .DATA_WD(64)) if0 ();
  id_inst_queue_if #(.DEPTH(4), .DATA_WD(64)) if1 ();
  id_inst_queue_if #(.DEPTH(4), .DATA_WD(64)) if2 ();

  id_inst_queue #(.DEPTH(4), .DATA_WD(64), .DELAY_SLOT(1), .SKIP_INFL(0)) dut0 (
    .clk(clk), .reset(reset), .q(if0.slave));
  id_inst_queue #(.DEPTH(4), .DATA_WD(64), .DELAY_SLOT(1), .SKIP_INFL(1)) dut1 (
    .clk(clk), .reset(reset), .q(if1.slave));
  id_inst_queue #(.DEPTH(4), .DATA_WD(64), .DELAY_SLOT(0), .SKIP_INFL(0)) dut2 (
    .clk(clk), .reset(reset), .q(if2.slave));

  logic        o_allow [3];
  logic        o_valid [3];
  logic [63:0] o_head  [3];
  logic [2:0]  o_occ   [3];

  assign o_allow[0] = if0.ID_allow_in;  assign o_valid[0] = if0.ID_to_EXE_valid;
  assign o_head[0]  = if0.head_bus;     assign o_occ[0]   = if0.occupancy;
  assign o_allow[1] = if1.ID_allow_in;  assign o_valid[1] = if1.ID_to_EXE_valid;
  assign o_head[1]  = if1.head_bus;     assign o_occ[1]   = if1.occupancy;
  assign o_allow[2] = if2.ID_allow_in;  assign o_valid[2] = if2.ID_to_EXE_valid;
  assign o_head[2]  = if2.head_bus;     assign o_occ[2]   = if2.occupancy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit cfg_ds(input int k);
    return (k != 2);
  endfunction

  function automatic int cfg_skip(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int k, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL cfg%0d %s: got %h expected %h at %0t", k, name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mcnt[k]  = 0;
      mdsw[k]  = 1'b0;
      mskip[k] = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] bus, input logic st, input logic exe, input logic br);
    if0.IF_to_ID_valid = v; if0.IF_to_ID_bus = bus; if0.ST_ready = st;
    if0.EXE_allow_in = exe; if0.br_redirect = br;
    if1.IF_to_ID_valid = v; if1.IF_to_ID_bus = bus; if1.ST_ready = st;
    if1.EXE_allow_in = exe; if1.br_redirect = br;
    if2.IF_to_ID_valid = v; if2.IF_to_ID_bus = bus; if2.ST_ready = st;
    if2.EXE_allow_in = exe; if2.br_redirect = br;
  endtask

  // One clock of stimulus: predict this cycle's outputs, then advance the model.
  task automatic cycle(input logic v, input logic [63:0] bus, input logic st, input logic exe, input logic br);
    exp_t e;
    bit   push;
    bit   pop;
    @(negedge clk);
    drive(v, bus, st, exe, br);
    for (int k = 0; k < 3; k++) begin
      e.k     = 2'(k);
      e.allow = (mcnt[k] != 4);
      e.valid = (mcnt[k] != 0) && st;
      e.head  = (mcnt[k] != 0) ? mq[k][0] : 64'd0;
      e.occ   = 3'(mcnt[k]);
      sb.push_back(e);
      push = v && e.allow;
      pop  = e.valid && exe;
      if (pop && br) begin
        mdsw[k]  = 1'b0;
        mskip[k] = cfg_skip(k);
        if (cfg_ds(k)) begin
          if (mcnt[k] >= 2) begin
            mq[k][0] = mq[k][1];
            mcnt[k]  = 1;
          end else if (push) begin
            mq[k][0] = bus;
            mcnt[k]  = 1;
          end else begin
            mcnt[k]  = 0;
            mdsw[k]  = 1'b1;
            mskip[k] = 0;
          end
        end else begin
          mcnt[k] = 0;
        end
      end else begin
        if (pop) begin
          for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i+1];
          mcnt[k]--;
        end
        if (push) begin
          if (mskip[k] != 0) begin
            mskip[k]--;
          end else begin
            mq[k][mcnt[k]] = bus;
            mcnt[k]++;
            if (mdsw[k]) begin
              mdsw[k]  = 1'b0;
              mskip[k] = cfg_skip(k);
            end
          end
        end
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
  endtask

  // Asynchronous reset mid-stall: outputs must clear with no clock edge.
  task automatic async_reset_check();
    @(negedge clk);
    drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_occ",   k, 64'(o_occ[k]),   64'd0);
      chk("rst_valid", k, 64'(o_valid[k]), 64'd0);
      chk("rst_head",  k, o_head[k],       64'd0);
      chk("rst_allow", k, 64'(o_allow[k]), 64'd1);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: consume the expectations for each cycle once outputs settle.
  initial begin
    exp_t e;
    int   kk;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() != 0) begin
        e  = sb.pop_front();
        kk = int'(e.k);
        chk("allow", kk, 64'(o_allow[kk]), 64'(e.allow));
        chk("valid", kk, 64'(o_valid[kk]), 64'(e.valid));
        chk("head",  kk, o_head[kk],       e.head);
        chk("occ",   kk, 64'(o_occ[kk]),   64'(e.occ));
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Fill to DEPTH while stalled; the fifth offer is held off; then drain in order.
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'hA000_0000_0000_0000 + 64'(i), 1'b0, 1'b0, 1'b0);
    drain(5);

    // Concurrent push/pop at occupancy 2 across pointer wrap.
    for (int i = 0; i < 2; i++) cycle(1'b1, 64'hB000_0000_0000_0000 + 64'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 2; i < 12; i++) cycle(1'b1, 64'hB000_0000_0000_0000 + 64'(i), 1'b1, 1'b1, 1'b0);
    drain(3);

    // Redirect at occupancy 3 (branch, ds, X) with a same-cycle push Y.
    cycle(1'b1, 64'hC000_0000_0000_00B0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'hC000_0000_0000_00D5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'hC000_0000_0000_00EE, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'hC000_0000_0000_00FF, 1'b1, 1'b1, 1'b1);
    drain(3);
    cycle(1'b1, 64'hC000_0000_0000_0011, 1'b0, 1'b0, 1'b0);
    drain(2);

    // Redirect at occupancy 1 with no push: P is the delay slot, Q skipped, R kept.
    cycle(1'b1, 64'hD000_0000_0000_00B0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 64'd0,                   1'b1, 1'b1, 1'b1);
    cycle(1'b1, 64'hD000_0000_0000_00A1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'hD000_0000_0000_00A2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'hD000_0000_0000_00A3, 1'b0, 1'b0, 1'b0);
    drain(4);

    // Full queue redirect with a same-cycle push (flush-all in config 2).
    for (int i = 0; i < 4; i++) cycle(1'b1, 64'hE000_0000_0000_0000 + 64'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'hE000_0000_0000_00FF, 1'b1, 1'b1, 1'b1);
    drain(2);
    cycle(1'b1, 64'hE000_0000_0000_0077, 1'b0, 1'b0, 1'b0);
    drain(2);

    // Asynchronous reset with three entries stored, then normal operation.
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'hF000_0000_0000_0000 + 64'(i), 1'b0, 1'b0, 1'b0);
    async_reset_check();
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'hF100_0000_0000_0000 + 64'(i), 1'b1, 1'b1, 1'b0);
    drain(3);

    // Randomised traffic with frequent stalls and redirects.
    for (int i = 0; i < 1500; i++) begin
      cycle(1'b1 && ($urandom_range(0, 3) != 0),
            {$urandom, $urandom},
            1'b1 && ($urandom_range(0, 9) < 7),
            1'b1 && ($urandom_range(0, 9) < 7),
            1'b1 && ($urandom_range(0, 4) == 0));
    end
    drain(5);

    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
